// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and its picker.
package mux8_rr_arbiter_pkg;

    localparam int N      = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    // The legacy state codes are the source of truth; the enum is built from them
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_t;

    // Turn a requester index into its one-hot grant vector
    function automatic logic [N-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin picker: finds the first eligible request at or
// above ptr, wrapping from 7 back to 0, ignoring any bit set in excl.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N-1:0]     excl,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0]     cand;
    logic [SEL_W-1:0] pos;

    // Scan from the farthest offset down so the closest eligible bit to ptr wins
    always_comb begin
        cand  = req & ~excl;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the 3-bit select of the 8:1 data selector.
// One requester holds the path at a time; a holder is forced off after
// MAX_HOLD cycles whenever someone else is waiting, and the chosen data bit
// is registered one cycle behind the grant.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     data,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             out,
    output logic             out_vld
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    logic [0:0]        state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              take_pick;
    logic              go_idle;

    // The current holder is the only bit ever excluded, and gnt already marks it
    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr),
        .excl  (gnt),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy = (state == ST_GRANT);

    // Decide whether this edge moves the grant to the picked requester or drops to idle
    always_comb begin
        take_pick = 1'b0;
        go_idle   = 1'b0;
        if (state == ST_IDLE) begin
            take_pick = pick_found;
        end else if (!req[sel]) begin
            take_pick = pick_found;
            go_idle   = !pick_found;
        end else if ((hold_cnt == MAX_HOLD_C) && pick_found) begin
            take_pick = 1'b1;
        end
    end

    // Grant, select, rotation pointer and hold counter update together on each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (take_pick) begin
            state    <= ST_GRANT;
            gnt      <= onehot8(pick_idx);
            sel      <= pick_idx;
            ptr      <= pick_idx + SEL_W'(1);
            hold_cnt <= HOLD_W'(1);
        end else if (go_idle) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
        end else if ((state == ST_GRANT) && (hold_cnt != MAX_HOLD_C)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Register the selected data bit one cycle behind the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out     <= busy ? data[sel] : 1'b0;
            out_vld <= busy;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios followed by a
// long random run compared against a behavioural round-robin model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD   = 4;
    localparam int FAIR_LIMIT = 7 * MAX_HOLD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic       out_vld;

    int checks = 0;
    int errors = 0;

    // Reference model: holder index (-1 = nobody), rotation start, hold length
    int   m_holder;
    int   m_ptr;
    int   m_hold;
    logic m_out;
    logic m_vld;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .out     (out),
        .out_vld (out_vld)
    );

    always #5 clk = ~clk;

    // Global time limit so the bench can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int rr_pick(input logic [7:0] r, input int start, input int skip);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (j != skip && r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_gnt();
        logic [7:0] v;
        v = 8'h00;
        if (m_holder >= 0) v[m_holder] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] model_sel();
        return (m_holder >= 0) ? 3'(m_holder) : 3'd0;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_hold   = 0;
        m_out    = 1'b0;
        m_vld    = 1'b0;
    endtask

    task automatic model_grant(input int p);
        m_holder = p;
        m_hold   = 1;
        m_ptr    = (p + 1) % 8;
    endtask

    task automatic model_edge(input logic [7:0] r, input logic [7:0] d);
        int p;
        m_out = (m_holder >= 0) ? d[m_holder] : 1'b0;
        m_vld = (m_holder >= 0);
        if (m_holder < 0) begin
            p = rr_pick(r, m_ptr, -1);
            if (p >= 0) model_grant(p);
        end else begin
            p = rr_pick(r, m_ptr, m_holder);
            if (!r[m_holder]) begin
                if (p >= 0) model_grant(p);
                else begin
                    m_holder = -1;
                    m_hold   = 0;
                end
            end else if (m_hold == MAX_HOLD && p >= 0) begin
                model_grant(p);
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    task automatic step();
        model_edge(req, data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        data  = 8'h00;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        data  = 8'hFF;
        #3;
        checks++;
        if ({gnt, sel, busy, out, out_vld} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_initial: gnt=%h sel=%0d busy=%b out=%b out_vld=%b, expected all 0",
                     gnt, sel, busy, out, out_vld);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, sel, busy, out, out_vld} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_held: gnt=%h sel=%0d busy=%b out=%b out_vld=%b, expected all 0",
                     gnt, sel, busy, out, out_vld);
        end
        req = 8'h00;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({gnt, sel, busy, out, out_vld} !== 14'd0) begin
                errors++;
                $display("[TB] FAIL reset_idle[%0d]: gnt=%h sel=%0d busy=%b out=%b out_vld=%b, expected all 0",
                         i, gnt, sel, busy, out, out_vld);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req  = 8'h20;
        data = 8'h20;
        step();
        checks++;
        if (gnt !== 8'h20 || sel !== 3'd5 || busy !== 1'b1 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_grant: gnt=%h sel=%0d busy=%b out_vld=%b, expected gnt=20 sel=5 busy=1 out_vld=0",
                     gnt, sel, busy, out_vld);
        end
        step();
        checks++;
        if (out !== 1'b1 || out_vld !== 1'b1 || sel !== 3'd5) begin
            errors++;
            $display("[TB] FAIL single_out: out=%b out_vld=%b sel=%0d, expected out=1 out_vld=1 sel=5",
                     out, out_vld, sel);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (gnt !== 8'h20 || sel !== 3'd5 || out !== 1'b1 || out_vld !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_hold[%0d]: gnt=%h sel=%0d out=%b out_vld=%b, expected gnt=20 sel=5 out=1 out_vld=1",
                         i, gnt, sel, out, out_vld);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_seq [12] = '{0, 0, 0, 0, 7, 7, 7, 7, 0, 0, 0, 0};
        logic [7:0] exp_gnt;
        do_reset();
        req  = 8'h81;
        data = 8'(($urandom));
        for (int i = 0; i < 12; i++) begin
            step();
            exp_gnt = 8'h00;
            exp_gnt[exp_seq[i]] = 1'b1;
            checks++;
            if (sel !== 3'(exp_seq[i]) || gnt !== exp_gnt) begin
                errors++;
                $display("[TB] FAIL wrap[%0d]: sel=%0d gnt=%h, expected sel=%0d gnt=%h",
                         i, sel, gnt, exp_seq[i], exp_gnt);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req  = 8'h06;
        data = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (sel !== 3'd1 || gnt !== 8'h02 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL early_hold[%0d]: sel=%0d gnt=%h busy=%b, expected sel=1 gnt=02 busy=1",
                         i, sel, gnt, busy);
            end
        end
        req = 8'h04;
        step();
        checks++;
        if (sel !== 3'd2 || gnt !== 8'h04 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_switch: sel=%0d gnt=%h busy=%b, expected sel=2 gnt=04 busy=1",
                     sel, gnt, busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req  = 8'h08;
        data = 8'h08;
        step();
        step();
        checks++;
        if (sel !== 3'd3 || out_vld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_setup: sel=%0d out_vld=%b, expected sel=3 out_vld=1", sel, out_vld);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || out_vld !== 1'b0 || busy !== 1'b0 || out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: gnt=%h sel=%0d busy=%b out=%b out_vld=%b, expected all 0",
                     gnt, sel, busy, out, out_vld);
        end
        req = 8'h18;
        #2;
        rst_n = 1'b1;
        model_reset();
        step();
        checks++;
        if (sel !== 3'd3 || gnt !== 8'h08) begin
            errors++;
            $display("[TB] FAIL midreset_regrant: sel=%0d gnt=%h, expected sel=3 gnt=08", sel, gnt);
        end
        repeat (MAX_HOLD) step();
        checks++;
        if (sel !== 3'd4 || gnt !== 8'h10) begin
            errors++;
            $display("[TB] FAIL midreset_rotate: sel=%0d gnt=%h, expected sel=4 gnt=10", sel, gnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int         wait_cnt [8];
        do_reset();
        r = 8'h00;
        for (int b = 0; b < 8; b++) wait_cnt[b] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            req  = r;
            data = 8'($urandom);
            step();
            checks++;
            if (gnt !== model_gnt() || sel !== model_sel() || busy !== (m_holder >= 0)) begin
                errors++;
                $display("[TB] FAIL random_grant[%0d]: gnt=%h sel=%0d busy=%b, expected gnt=%h sel=%0d busy=%b",
                         cyc, gnt, sel, busy, model_gnt(), model_sel(), (m_holder >= 0));
            end
            checks++;
            if (out !== m_out || out_vld !== m_vld) begin
                errors++;
                $display("[TB] FAIL random_out[%0d]: out=%b out_vld=%b, expected out=%b out_vld=%b",
                         cyc, out, out_vld, m_out, m_vld);
            end
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("[TB] FAIL random_onehot[%0d]: gnt=%h, expected one-hot or zero", cyc, gnt);
            end
            for (int b = 0; b < 8; b++) begin
                if (req[b] && !gnt[b]) wait_cnt[b]++;
                else wait_cnt[b] = 0;
            end
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (wait_cnt[b] > FAIR_LIMIT) begin
                    errors++;
                    $display("[TB] FAIL random_fairness[%0d]: requester %0d waited %0d cycles, limit %0d",
                             cyc, b, wait_cnt[b], FAIR_LIMIT);
                    wait_cnt[b] = 0;
                end
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_wrap();
        test_early_release();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
